// File: rtl/hamming_decoder72.sv
// hamming_decoder72: serial 72/64 SECDED decoder, 8-bit slice syndrome scan, valid/ready in and out.
// Optional error counters built when HAMMING_DEC_ERR_CNT_EN is defined.
module hamming_decoder72 (
  input  logic        clk,
  input  logic        rst,
  input  logic [71:0] code_in,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] data_out,
  output logic [6:0]  syndrome,
  output logic        err_single,
  output logic        err_uncorr,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        cnt_clr,
  output logic [15:0] cnt_single,
  output logic [15:0] cnt_uncorr
);
  typedef enum logic [1:0] {IDLE, SCAN, FIX, OUT} state_t;
  state_t state_q, state_d;
  logic [71:0] code_q, fixed;
  logic [3:0]  k_q;
  logic [6:0]  acc_q, syn_q, slice_syn;
  logic [7:0]  slice;
  logic [5:0]  n;
  logic [63:0] data_q, dx;
  logic        par_q, slice_par, ok_fix, uncorr, es_q, eu_q, ov_q;
  always_comb begin
    slice = code_q[{k_q, 3'b000} +: 8];
    slice_syn = '0;
    for (int j = 0; j < 8; j++) slice_syn = slice_syn ^ (slice[j] ? {k_q, 3'(j)} : 7'd0);
    slice_par = ^slice;
  end
  // Correctable covers S=0 (bit-0 error) too; flipping bit 0 never touches data.
  assign ok_fix = par_q && acc_q <= 7'd71;
  assign uncorr = acc_q != 7'd0 && !ok_fix;
  always_comb begin
    fixed = ok_fix ? code_q ^ (72'd1 << acc_q) : code_q;
    dx = '0;
    n = '0;
    for (int i = 3; i < 72; i++)
      if ((i & (i - 1)) != 0) begin
        dx[n] = fixed[i];
        n = n + 6'd1;
      end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = in_valid ? SCAN : IDLE;
      SCAN: state_d = k_q == 4'd8 ? FIX : SCAN;
      FIX:  state_d = OUT;
      OUT:  state_d = out_ready ? IDLE : OUT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      code_q  <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      syn_q   <= '0;
      es_q    <= 1'b0;
      eu_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (in_valid) begin
          code_q <= code_in;
          acc_q  <= '0;
          par_q  <= 1'b0;
          k_q    <= '0;
        end
        SCAN: begin
          acc_q <= acc_q ^ slice_syn;
          par_q <= par_q ^ slice_par;
          k_q   <= k_q + 4'd1;
        end
        FIX: begin
          data_q <= dx;
          syn_q  <= acc_q;
          es_q   <= ok_fix;
          eu_q   <= uncorr;
          ov_q   <= 1'b1;
        end
        OUT: if (out_ready) ov_q <= 1'b0;
      endcase
    end
  end
  assign in_ready   = state_q == IDLE;
  assign data_out   = data_q;
  assign syndrome   = syn_q;
  assign err_single = es_q;
  assign err_uncorr = eu_q;
  assign out_valid  = ov_q;
`ifdef HAMMING_DEC_ERR_CNT_EN
  logic [15:0] cs_q, cu_q;
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cs_q <= '0;
      cu_q <= '0;
    end else if (state_q == FIX) begin
      if (ok_fix && cs_q != 16'hFFFF) cs_q <= cs_q + 16'd1;
      if (uncorr && cu_q != 16'hFFFF) cu_q <= cu_q + 16'd1;
    end
  end
  assign cnt_single = cs_q;
  assign cnt_uncorr = cu_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_single = '0;
  assign cnt_uncorr = '0;
`endif
endmodule

// File: tb/tb_hamming_decoder72.sv
// tb_hamming_decoder72: randomized self-checking bench with a positional SECDED reference model.
module tb_hamming_decoder72;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, cnt_clr = 1'b0;
  logic [71:0] code_in = '0;
  logic        in_ready, err_single, err_uncorr, out_valid;
  logic [63:0] data_out;
  logic [6:0]  syndrome;
  logic [15:0] cnt_single, cnt_uncorr;
  int errors = 0, checks = 0, cyc = 0, last_acc = 0, exp_cs = 0, exp_cu = 0;

  hamming_decoder72 dut (
    .clk(clk), .rst(rst), .code_in(code_in), .in_valid(in_valid), .in_ready(in_ready),
    .data_out(data_out), .syndrome(syndrome), .err_single(err_single), .err_uncorr(err_uncorr),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .cnt_single(cnt_single), .cnt_uncorr(cnt_uncorr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit is_parity_pos(input int i);
    return i == 0 || $countones(i) == 1;
  endfunction

  function automatic logic [71:0] encode(input logic [63:0] d);
    logic [71:0] c = '0;
    int j = 0;
    for (int i = 1; i < 72; i++) if (!is_parity_pos(i)) begin c[i] = d[j]; j++; end
    for (int p = 0; p < 7; p++) begin
      logic b = 1'b0;
      for (int i = 1; i < 72; i++) if ((i >> p) % 2 == 1 && !is_parity_pos(i)) b ^= c[i];
      c[1 << p] = b;
    end
    c[0] = ^c;
    return c;
  endfunction

  task automatic model(input logic [71:0] c, output logic [63:0] d, output logic [6:0] s,
                       output bit es, output bit eu);
    int syn = 0, j = 0;
    bit par = ^c;
    logic [71:0] f = c;
    for (int i = 1; i < 72; i++) if (c[i]) syn ^= i;
    es = par && syn <= 71;
    eu = syn != 0 && !es;
    if (es) f[syn] = ~f[syn];
    d = '0;
    for (int i = 1; i < 72; i++) if (!is_parity_pos(i)) begin d[j] = f[i]; j++; end
    s = 7'(syn);
  endtask

  task automatic send(input logic [71:0] c, input int hold, input bit clr_fix, input bit chk_gap);
    logic [63:0] ed;
    logic [6:0]  esyn;
    bit es, eu;
    int n = 0;
    model(c, ed, esyn, es, eu);
    @(negedge clk);
    in_valid = 1'b1; code_in = c; out_ready = hold == 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL in_ready_idle got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0; code_in = {8'($urandom), $urandom, $urandom};
    if (chk_gap) begin
      checks++; if (cyc - last_acc != 12) begin errors++; $display("FAIL throughput got=%0d exp=12", cyc - last_acc); end
    end
    last_acc = cyc;
    while (out_valid !== 1'b1 && n < 30) begin
      if (clr_fix && n == 9) cnt_clr = 1'b1;
      @(posedge clk); #1; n++;
    end
    cnt_clr = 1'b0;
    checks++; if (n != 10) begin errors++; $display("FAIL latency got=%0d exp=10", n); end
`ifdef HAMMING_DEC_ERR_CNT_EN
    if (clr_fix) begin exp_cs = 0; exp_cu = 0; end
    else begin
      if (es && exp_cs < 65535) exp_cs++;
      if (eu && exp_cu < 65535) exp_cu++;
    end
`endif
    checks++; if (data_out !== ed) begin errors++; $display("FAIL data got=%0h exp=%0h", data_out, ed); end
    checks++; if (syndrome !== esyn) begin errors++; $display("FAIL syndrome got=%0d exp=%0d", syndrome, esyn); end
    checks++; if (err_single !== es) begin errors++; $display("FAIL err_single got=%0b exp=%0b", err_single, es); end
    checks++; if (err_uncorr !== eu) begin errors++; $display("FAIL err_uncorr got=%0b exp=%0b", err_uncorr, eu); end
    checks++; if (cnt_single !== 16'(exp_cs)) begin errors++; $display("FAIL cnt_single got=%0d exp=%0d", cnt_single, exp_cs); end
    checks++; if (cnt_uncorr !== 16'(exp_cu)) begin errors++; $display("FAIL cnt_uncorr got=%0d exp=%0d", cnt_uncorr, exp_cu); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); in_valid = 1'b1; code_in = {8'($urandom), $urandom, $urandom};
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || data_out !== ed || syndrome !== esyn) begin
        errors++; $display("FAIL hold cyc=%0d ov=%0b ir=%0b data=%0h syn=%0d exp_data=%0h exp_syn=%0d",
                            h, out_valid, in_ready, data_out, syndrome, ed, esyn);
      end
    end
    if (hold > 0) begin @(negedge clk); in_valid = 1'b0; out_ready = 1'b1; end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL handshake ov=%0b ir=%0b exp ov=0 ir=1", out_valid, in_ready);
    end
    checks++; if (data_out !== ed) begin errors++; $display("FAIL data_kept got=%0h exp=%0h", data_out, ed); end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || data_out !== 64'h0 || syndrome !== 7'h0 ||
        err_single !== 1'b0 || err_uncorr !== 1'b0 || cnt_single !== 16'h0 || cnt_uncorr !== 16'h0) begin
      errors++;
      $display("FAIL %s ir=%0b ov=%0b data=%0h syn=%0d es=%0b eu=%0b cs=%0d cu=%0d exp ir=1 rest 0",
               tag, in_ready, out_valid, data_out, syndrome, err_single, err_uncorr, cnt_single, cnt_uncorr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    @(negedge clk) rst = 1'b0;
  endtask

  task automatic test_rst_mid_scan();
    send(encode(64'hDEAD_BEEF_0123_4567), 0, 1'b0, 1'b0);
    @(negedge clk); in_valid = 1'b1; code_in = encode(64'h55) ^ 72'h3;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1 check_reset_vals("rst_mid_scan");
    @(negedge clk) rst = 1'b0;
    exp_cs = 0; exp_cu = 0;
    send(encode(64'h0F0F_0000_FFFF_1234), 0, 1'b0, 1'b0);
  endtask

  task automatic test_vectors();
    logic [71:0] vc [6] = '{72'h0, 72'hF, 72'h80_0000_0000_0000_000F, 72'h6,
                             72'h01_0000_0000_0000_0102, 72'h1};
    logic [63:0] vd [6] = '{64'h0, 64'h1, 64'h1, 64'h0, 64'h0, 64'h0};
    logic [6:0]  vs [6] = '{7'd0, 7'd0, 7'd71, 7'd3, 7'd73, 7'd0};
    logic [1:0]  vf [6] = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b10};
    for (int t = 0; t < 6; t++) begin
      send(vc[t], 0, 1'b0, 1'b0);
      checks++;
      if (data_out !== vd[t] || syndrome !== vs[t] || {err_single, err_uncorr} !== vf[t]) begin
        errors++;
        $display("FAIL vector%0d data=%0h syn=%0d flags=%0b exp data=%0h syn=%0d flags=%0b",
                 t, data_out, syndrome, {err_single, err_uncorr}, vd[t], vs[t], vf[t]);
      end
    end
  endtask

  task automatic test_backpressure();
    send(encode(64'hCAFE_F00D_1357_9BDF) ^ (72'd1 << 40), 20, 1'b0, 1'b0);
    checks++; if (data_out !== 64'hCAFE_F00D_1357_9BDF) begin
      errors++; $display("FAIL bp_corrected got=%0h exp=cafef00d13579bdf", data_out);
    end
  endtask

  task automatic test_counters();
    logic [63:0] d;
    int e1, e2;
    @(negedge clk) cnt_clr = 1'b1;
    @(posedge clk); #1 cnt_clr = 1'b0;
    exp_cs = 0; exp_cu = 0;
    for (int t = 0; t < 4; t++) begin
      d = {$urandom, $urandom};
      e1 = $urandom_range(1, 71);
      e2 = (e1 + $urandom_range(1, 70)) % 72;
      send(encode(d) ^ (72'd1 << e1) ^ (t == 3 ? (72'd1 << e2) : 72'd0), 0, 1'b0, 1'b0);
    end
`ifdef HAMMING_DEC_ERR_CNT_EN
    checks++; if (cnt_single !== 16'd3 || cnt_uncorr !== 16'd1) begin
      errors++; $display("FAIL cnt_totals got=%0d/%0d exp=3/1", cnt_single, cnt_uncorr);
    end
`else
    checks++; if (cnt_single !== 16'd0 || cnt_uncorr !== 16'd0) begin
      errors++; $display("FAIL cnt_disabled got=%0d/%0d exp=0/0", cnt_single, cnt_uncorr);
    end
`endif
    send(encode(64'h1) ^ 72'h20, 0, 1'b1, 1'b0);
    checks++; if (cnt_single !== 16'd0 || cnt_uncorr !== 16'd0) begin
      errors++; $display("FAIL cnt_clr_at_fix got=%0d/%0d exp=0/0", cnt_single, cnt_uncorr);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d;
    logic [71:0] c;
    int nf, p1, p2;
    for (int t = 0; t < 40; t++) begin
      d = {$urandom, $urandom};
      nf = $urandom_range(0, 3);
      p1 = $urandom_range(0, 71);
      p2 = (p1 + $urandom_range(1, 71)) % 72;
      c = encode(d);
      if (nf >= 1) c[p1] = ~c[p1];
      if (nf == 2) c[p2] = ~c[p2];
      if (nf == 3) c = {8'($urandom), $urandom, $urandom};
      send(c, 0, 1'b0, t > 0);
      if (nf <= 1) begin
        checks++; if (data_out !== d) begin errors++; $display("FAIL rand_recover got=%0h exp=%0h", data_out, d); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rst_mid_scan();
    test_vectors();
    test_backpressure();
    test_counters();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
